tlc5941_receiver: RTL
=====================

Name: tlc5941_receiver

Overview:
- Cycle-accurate, synthesizable model of one TLC5941 16-channel LED driver, seen from the device side of the serial interface.
- Deserializes SIN on SCLK rising edges and latches grayscale (GS) or dot-correction (DC) data on XLAT. Runs the 12-bit GSCLK/BLANK PWM counter and drives 16 channel-on outputs.
- Used in simulation and on-board loopback to check the pixel driver end-to-end. SOUT allows three instances to be daisy-chained as R, G, B, as on the panel.

Parameters:
- EXPECT_GS_BITS, 192: SCLK edges expected between XLATs in GS mode. Set to 576 for a 3-deep chain.
- EXPECT_DC_BITS, 96: SCLK edges expected between XLATs in DC mode. Set to 288 for a 3-deep chain.

Ports:
- clock  input  1  system clock; all interface inputs are sampled on it.
- reset  input  1  synchronous, active-high reset.
- sclk  input  1  serial data clock from the driver.
- sin  input  1  serial data in, MSB of channel 15 first.
- xlat  input  1  latch strobe; a rising edge latches data.
- mode  input  1  0 = GS (12 bits/channel), 1 = DC (6 bits/channel).
- blank  input  1  1 = outputs off and GS counter cleared.
- gsclk  input  1  PWM reference clock.
- sout  output  1  serial data out to the next device.
- ch_on  output  16  per-channel PWM output, 1 = LED on.
- rd_ch  input  4  readback channel select.
- rd_gs  output  12  latched GS value of rd_ch (combinational read).
- rd_dc  output  6  latched DC value of rd_ch (combinational read).
- xlat_count  output  16  number of XLAT rising edges since reset; wraps.
- frame_error  output  1  sticky flag: an XLAT arrived with the wrong bit count.

Behaviour:
- Input sampling:
  - sclk, sin, xlat, mode, blank and gsclk are registered once into *_q, and the previous sclk_q, xlat_q and gsclk_q are kept.
  - Rising edge = q & ~prev. Each edge is acted on in the cycle after it is seen, so latency is 2 clocks from pin to effect.
  - No metastability synchronizers: all inputs come from the same clock domain.
- Shift register:
  - 192 bits; shifts left on an sclk edge with sin_q entering bit 0.
  - Channel n lives in bits [12n+11:12n] in GS mode and [6n+5:6n] in DC mode.
  - sout is registered: shift[191] when mode_q=0, shift[95] when mode_q=1. It updates in the same cycle as the shift.
- Bit counter:
  - 10 bits, increments on each sclk edge and saturates at 1023.
  - Cleared on each xlat edge. If the same cycle also has an sclk edge, the counter is cleared, not incremented.
- Latch (xlat edge), using mode_q sampled in that cycle:
  - mode 0: gs[n] <= the shift register's channel-n field.
  - mode 1: dc[n] <= the channel-n field from bits [95:0].
  - Simultaneous sclk and xlat edges: the shift happens first, and the latch captures the post-shift value.
  - xlat_count increments on every xlat edge.
- frame_error:
  - Set on an xlat edge when the bit count is not EXPECT_GS_BITS (mode 0) or not EXPECT_DC_BITS (mode 1).
  - Cleared only by reset. The latch still happens when the count is wrong.
- PWM counter:
  - 12-bit gs_cnt. While blank_q=1: gs_cnt <= 0 and ch_on <= 0.
  - Otherwise, a gsclk edge increments gs_cnt, saturating at 4095 with no wrap.
  - ch_on[n] is registered and equals ~blank_q & (gs_cnt < gs[n]). A gs[n] of 0 is never on.
  - A new GS latch takes effect on the next compare; the counter is not restarted.
  - DC values are stored and read back only; they do not scale the PWM.
- Reset:
  - Shift register, gs[], dc[], bit counter, gs_cnt, sout, ch_on, xlat_count, frame_error and all *_q/prev registers go to 0.
  - Reset mid-frame discards the partial shift. Edges already sampled in that cycle are ignored.

Test Plan:
- GS load: shift 192 bits with channel 15 = 0xABC, channel 0 = 0x123 and the rest 0, then raise xlat. Required: rd_gs(15)=0xABC, rd_gs(0)=0x123, xlat_count=1, frame_error=0.
- DC load: mode=1, shift 96 bits with every channel = 6'd7, then xlat. Required: rd_dc(n)=7 for all n and gs[] unchanged. Then mode=0 and shift 191 bits + xlat: frame_error=1.
- PWM: gs[3]=2, gs[4]=4095, gs[5]=0, blank pulse, then 4100 gsclk edges. Required: ch_on[3] high for exactly 2 gsclk periods, ch_on[4] falls at count 4095 and stays low, ch_on[5] never high. Asserting blank clears all outputs within 2 clocks.
- Chain: three instances via sout→sin, EXPECT_GS_BITS=576, driven by the pixel driver for 48 words. Required: last-sent word in device 0, channel 0; first-sent word in device 2, channel 15; no frame_error.
- Simultaneous edges: final sclk edge and xlat edge sampled in the same clock. Required: latch includes the final bit and the bit counter reads 0 afterwards.
- Reset mid-frame: reset after 100 sclk edges, then a full 192-bit frame. Required: correct gs[], frame_error=0, xlat_count=1.

Source files
------------

// File: rtl/tlc5941_receiver.sv
// Device-side model of one TLC5941 16-channel LED driver: serial shift-in,
// XLAT latching of grayscale / dot-correction data, and the 12-bit PWM engine.
// All interface pins are sampled on the system clock, so edges are detected
// from registered copies and acted on one cycle later.
module tlc5941_receiver #(
    parameter int unsigned EXPECT_GS_BITS = 192,
    parameter int unsigned EXPECT_DC_BITS = 96
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sclk,
    input  logic        sin,
    input  logic        xlat,
    input  logic        mode,
    input  logic        blank,
    input  logic        gsclk,
    output logic        sout,
    output logic [15:0] ch_on,
    input  logic [3:0]  rd_ch,
    output logic [11:0] rd_gs,
    output logic [5:0]  rd_dc,
    output logic [15:0] xlat_count,
    output logic        frame_error
);

    localparam logic [9:0] ExpGsBits = 10'(EXPECT_GS_BITS);
    localparam logic [9:0] ExpDcBits = 10'(EXPECT_DC_BITS);

    // Sampled pins and the previous samples used for edge detection
    logic sclk_q, sclk_prev_q, sin_q, xlat_q, xlat_prev_q;
    logic mode_q, blank_q, gsclk_q, gsclk_prev_q;

    logic [191:0] shift_q, shift_d;
    logic [191:0] gs_q, gs_d;         // channel n at [12n+11:12n]
    logic [95:0]  dc_q, dc_d;         // channel n at [6n+5:6n]
    logic [9:0]   bit_cnt_q, bit_cnt_d;
    logic [9:0]   bit_cnt_seen;       // count including an sclk edge in this cycle
    logic [11:0]  gs_cnt_q, gs_cnt_d;
    logic         sout_q, sout_d;
    logic [15:0]  ch_on_q, ch_on_d;
    logic [15:0]  xlat_count_q, xlat_count_d;
    logic         frame_error_q, frame_error_d;

    logic sclk_rise, xlat_rise, gsclk_rise;
    logic [7:0] gs_base;
    logic [6:0] dc_base;

    assign sclk_rise  = sclk_q & ~sclk_prev_q;
    assign xlat_rise  = xlat_q & ~xlat_prev_q;
    assign gsclk_rise = gsclk_q & ~gsclk_prev_q;

    // Register every interface pin once and keep the previous clock-like samples
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_q       <= 1'b0;
            sclk_prev_q  <= 1'b0;
            sin_q        <= 1'b0;
            xlat_q       <= 1'b0;
            xlat_prev_q  <= 1'b0;
            mode_q       <= 1'b0;
            blank_q      <= 1'b0;
            gsclk_q      <= 1'b0;
            gsclk_prev_q <= 1'b0;
        end else begin
            sclk_q       <= sclk;
            sclk_prev_q  <= sclk_q;
            sin_q        <= sin;
            xlat_q       <= xlat;
            xlat_prev_q  <= xlat_q;
            mode_q       <= mode;
            blank_q      <= blank;
            gsclk_q      <= gsclk;
            gsclk_prev_q <= gsclk_q;
        end
    end

    // Serial shift, bit counting and XLAT latching; the latch sees the post-shift value
    always_comb begin
        shift_d       = shift_q;
        gs_d          = gs_q;
        dc_d          = dc_q;
        xlat_count_d  = xlat_count_q;
        frame_error_d = frame_error_q;

        if (sclk_rise) begin
            shift_d = {shift_q[190:0], sin_q};
        end
        sout_d = mode_q ? shift_d[95] : shift_d[191];

        bit_cnt_seen = bit_cnt_q;
        if (sclk_rise && bit_cnt_q != 10'h3ff) begin
            bit_cnt_seen = bit_cnt_q + 10'd1;
        end
        bit_cnt_d = xlat_rise ? 10'd0 : bit_cnt_seen;

        if (xlat_rise) begin
            xlat_count_d = xlat_count_q + 16'd1;
            if (mode_q) begin
                dc_d = shift_d[95:0];
                if (bit_cnt_seen != ExpDcBits) frame_error_d = 1'b1;
            end else begin
                gs_d = shift_d;
                if (bit_cnt_seen != ExpGsBits) frame_error_d = 1'b1;
            end
        end
    end

    // PWM counter and per-channel compare; blank forces everything off
    always_comb begin
        gs_cnt_d = gs_cnt_q;
        ch_on_d  = 16'h0000;
        if (blank_q) begin
            gs_cnt_d = 12'd0;
        end else begin
            if (gsclk_rise && gs_cnt_q != 12'hfff) begin
                gs_cnt_d = gs_cnt_q + 12'd1;
            end
            for (int n = 0; n < 16; n++) begin
                ch_on_d[n] = (gs_cnt_q < gs_q[12*n +: 12]);
            end
        end
    end

    // Datapath state
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q       <= '0;
            gs_q          <= '0;
            dc_q          <= '0;
            bit_cnt_q     <= '0;
            gs_cnt_q      <= '0;
            sout_q        <= 1'b0;
            ch_on_q       <= '0;
            xlat_count_q  <= '0;
            frame_error_q <= 1'b0;
        end else begin
            shift_q       <= shift_d;
            gs_q          <= gs_d;
            dc_q          <= dc_d;
            bit_cnt_q     <= bit_cnt_d;
            gs_cnt_q      <= gs_cnt_d;
            sout_q        <= sout_d;
            ch_on_q       <= ch_on_d;
            xlat_count_q  <= xlat_count_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Readback: base = 12*rd_ch and 6*rd_ch built from shifts
    assign gs_base = {1'b0, rd_ch, 3'b000} + {2'b00, rd_ch, 2'b00};
    assign dc_base = {1'b0, rd_ch, 2'b00} + {2'b00, rd_ch, 1'b0};

    assign rd_gs       = gs_q[gs_base +: 12];
    assign rd_dc       = dc_q[dc_base +: 6];
    assign sout        = sout_q;
    assign ch_on       = ch_on_q;
    assign xlat_count  = xlat_count_q;
    assign frame_error = frame_error_q;

endmodule
